// File: rtl/clock_sequencer.sv
// Clock/run-control stage: divides the board clock into memory and gated processor/regfile
// clocks, runs a HOLD/RUN/HALT/STEP FSM with PC breakpoint, and counts executed core cycles.
module clock_sequencer #(
  parameter int DIV_LOG2     = 3,
  parameter int HOLD_PERIODS = 2,
  parameter bit START_RUN    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        halt,
  input  logic        step,
  input  logic        bp_en,
  input  logic [11:0] bp_addr,
  input  logic [11:0] pc,
  output logic        imem_clock,
  output logic        dmem_clock,
  output logic        processor_clock,
  output logic        regfile_clock,
  output logic        core_reset,
  output logic [1:0]  run_state,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_t;

  localparam int unsigned         PERIOD     = 1 << DIV_LOG2;
  localparam logic [DIV_LOG2-1:0] DP_PH      = DIV_LOG2'(PERIOD / 2);
  localparam logic [DIV_LOG2-1:0] LAST_PH    = DIV_LOG2'(PERIOD - 1);
  localparam logic [3:0]          HOLD_LIMIT = 4'(HOLD_PERIODS);

  logic [DIV_LOG2-1:0] ph;
  state_t              state, state_next;
  logic                gate_q, gate_next;
  logic [3:0]          hold_cnt, hold_next;
  logic                core_reset_next;
  logic                bp_armed, bp_armed_next;
  logic                step_q, step_pend, step_pend_next, step_done;
  logic                halt_pend;
  logic                at_dp, at_wrap, step_rise, halt_req, bp_hit;

  assign at_dp     = (ph == DP_PH);
  assign at_wrap   = (ph == LAST_PH);
  assign step_rise = step & ~step_q;
  // A halt request seen anywhere in the period is honoured at the next decision point.
  assign halt_req  = halt | halt_pend;
  assign bp_hit    = bp_en & bp_armed & (pc == bp_addr);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next      = state;
    gate_next       = gate_q;
    hold_next       = hold_cnt;
    core_reset_next = core_reset;
    bp_armed_next   = bp_armed;
    step_done       = 1'b0;
    if (at_dp) begin
      unique case (state)
        S_HOLD: begin
          if (hold_cnt < HOLD_LIMIT) begin
            hold_next = hold_cnt + 4'd1;
          end else begin
            core_reset_next = 1'b0;
            state_next      = START_RUN ? S_RUN : S_HALT;
          end
        end
        S_RUN: begin
          if (halt_req || bp_hit) state_next = S_HALT;
          bp_armed_next = bp_armed | (pc != bp_addr);
        end
        S_HALT: begin
          if (halt_req) begin
            state_next = S_HALT;
          end else if (step_pend) begin
            state_next = S_STEP;
          end else if (run) begin
            // Resuming on the breakpoint address must execute it once before re-arming.
            state_next    = S_RUN;
            bp_armed_next = 1'b0;
          end
        end
        S_STEP: begin
          state_next = S_HALT;
          step_done  = 1'b1;
        end
      endcase
      gate_next = (state_next != S_HALT);
    end
  end

  assign step_pend_next = (state == S_RUN || step_done) ? 1'b0 : (step_pend | step_rise);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph          <= '0;
      state       <= S_HOLD;
      gate_q      <= 1'b0;
      hold_cnt    <= 4'd0;
      core_reset  <= 1'b1;
      bp_armed    <= 1'b1;
      step_q      <= 1'b0;
      step_pend   <= 1'b0;
      halt_pend   <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      ph         <= ph + DIV_LOG2'(1);
      state      <= state_next;
      gate_q     <= gate_next;
      hold_cnt   <= hold_next;
      core_reset <= core_reset_next;
      bp_armed   <= bp_armed_next;
      step_q     <= step;
      step_pend  <= step_pend_next;
      halt_pend  <= at_dp ? 1'b0 : (halt_pend | halt);
      if (at_wrap && gate_q && !core_reset) cycle_count <= cycle_count + 32'd1;
    end
  end

  // gate_q only moves while ph[MSB] is high, so the gated clocks never glitch.
  assign imem_clock      = ph[0];
  assign dmem_clock      = ph[0];
  assign processor_clock = gate_q & ~ph[DIV_LOG2-1];
  assign regfile_clock   = processor_clock;
  assign run_state       = state;

endmodule

// File: tb/tb_clock_sequencer.sv
// Self-checking bench for clock_sequencer: directed scenarios plus randomized run/halt/step/
// breakpoint traffic, compared every cycle against a behavioural model of the run-control rules.
module tb_clock_sequencer;

  localparam int DIV_LOG2     = 3;
  localparam int HOLD_PERIODS = 2;
  localparam bit START_RUN    = 1'b1;
  localparam int P            = 1 << DIV_LOG2;
  localparam int HALF         = P / 2;
  localparam int S_HOLD = 0, S_RUN = 1, S_HALT = 2, S_STEP = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        run, halt, step, bp_en;
  logic [11:0] bp_addr, pc;
  logic        imem_clock, dmem_clock, processor_clock, regfile_clock, core_reset;
  logic [1:0]  run_state;
  logic [31:0] cycle_count;

  clock_sequencer #(
    .DIV_LOG2    (DIV_LOG2),
    .HOLD_PERIODS(HOLD_PERIODS),
    .START_RUN   (START_RUN)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .halt           (halt),
    .step           (step),
    .bp_en          (bp_en),
    .bp_addr        (bp_addr),
    .pc             (pc),
    .imem_clock     (imem_clock),
    .dmem_clock     (dmem_clock),
    .processor_clock(processor_clock),
    .regfile_clock  (regfile_clock),
    .core_reset     (core_reset),
    .run_state      (run_state),
    .cycle_count    (cycle_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: phase counter, run-control state and counters stepped per board clock.
  int          m_ph = 0;
  int          m_state = S_HOLD;
  int          m_hold = 0;
  bit          m_gate = 0, m_core_reset = 1, m_armed = 1;
  bit          m_step_pend = 0, m_step_prev = 0, m_halt_seen = 0;
  bit [31:0]   m_count = 0;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_ph = 0; m_state = S_HOLD; m_hold = 0; m_gate = 0; m_core_reset = 1; m_armed = 1;
      m_step_pend = 0; m_step_prev = 0; m_halt_seen = 0; m_count = 0;
    end else begin
      bit dp, rise, hreq;
      int nxt;
      dp   = (m_ph == HALF);
      rise = step && !m_step_prev;
      hreq = halt || m_halt_seen;
      if (m_ph == P - 1 && m_gate && !m_core_reset) m_count = m_count + 1;
      nxt = m_state;
      if (dp) begin
        if (m_state == S_HOLD) begin
          if (m_hold < HOLD_PERIODS) m_hold = m_hold + 1;
          else begin m_core_reset = 0; nxt = START_RUN ? S_RUN : S_HALT; end
        end else if (m_state == S_RUN) begin
          if (hreq || (bp_en && m_armed && pc == bp_addr)) nxt = S_HALT;
          if (pc != bp_addr) m_armed = 1;
        end else if (m_state == S_HALT) begin
          if (!hreq && m_step_pend) nxt = S_STEP;
          else if (!hreq && run) begin nxt = S_RUN; m_armed = 0; end
        end else begin
          nxt = S_HALT;
        end
        m_gate = (nxt != S_HALT);
      end
      if (m_state == S_RUN || (dp && m_state == S_STEP)) m_step_pend = 0;
      else m_step_pend = m_step_pend || rise;
      m_halt_seen = dp ? 1'b0 : (m_halt_seen || halt);
      m_step_prev = step;
      m_state = nxt;
      m_ph = (m_ph + 1) % P;
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      check("imem_clock", imem_clock, m_ph % 2);
      check("dmem_clock", dmem_clock, m_ph % 2);
      check("processor_clock", processor_clock, (m_gate && m_ph < HALF));
      check("regfile_clock", regfile_clock, (m_gate && m_ph < HALF));
      check("core_reset", core_reset, m_core_reset);
      check("run_state", run_state, m_state);
      check("cycle_count", cycle_count, m_count);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: pc follows observed processor edges; pulse widths are checked on each fall.
  int edges = 0;
  int hi_len = 0;
  bit prev_proc = 0;

  task automatic step_clk();
    @(negedge clock);
    if (!reset) begin
      hi_len = 0;
      prev_proc = 0;
    end else begin
      if (processor_clock && !prev_proc) begin
        pc = pc + 12'd1;
        edges++;
      end
      if (processor_clock) hi_len++;
      else if (prev_proc) begin
        check("proc_pulse_width", hi_len, HALF);
        hi_len = 0;
      end
      prev_proc = processor_clock;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) step_clk();
  endtask

  task automatic wait_ph(input int p);
    int k = 0;
    while (m_ph != p && k < 2 * P) begin step_clk(); k++; end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k = 0;
    while (run_state != 2'(s) && k < budget) begin step_clk(); k++; end
    check(name, run_state, s);
  endtask

  initial begin
    int k;
    reset = 1'b0; run = 0; halt = 0; step = 0; bp_en = 0; bp_addr = 12'h000; pc = 12'h000;

    // T1: reset, hold sequence, first counted edge
    tick(2);
    cmp_en = 1;
    tick(3);
    check("t1_rst_core_reset", core_reset, 1);
    check("t1_rst_state", run_state, S_HOLD);
    check("t1_rst_count", cycle_count, 0);
    check("t1_rst_proc_clk", processor_clock, 0);
    check("t1_rst_imem_clk", imem_clock, 0);
    reset = 1'b1;
    edges = 0;
    tick(4);
    check("t1_no_edge_first_dp", processor_clock, 0);
    tick(16);
    check("t1_core_reset_held", core_reset, 1);
    check("t1_edges_in_reset", edges, 2);
    tick(1);
    check("t1_core_reset_release", core_reset, 0);
    check("t1_state_run", run_state, S_RUN);
    tick(3);
    check("t1_first_counted_edge", processor_clock, 1);
    check("t1_count_one", cycle_count, 1);

    // T2: one-clock halt pulse at ph=1
    wait_ph(1);
    halt = 1; step_clk(); halt = 0;
    wait_state(S_HALT, 2 * P, "t2_halted");
    edges = 0;
    tick(3 * P);
    check("t2_no_edges_halted", edges, 0);
    check("t2_still_halt", run_state, S_HALT);

    // T3: single step, then two pulses inside one period
    edges = 0;
    step = 1; step_clk(); step = 0;
    tick(3 * P);
    check("t3_single_step_edges", edges, 1);
    check("t3_back_to_halt", run_state, S_HALT);
    wait_ph(5);
    edges = 0;
    step = 1; step_clk(); step = 0; step_clk();
    step = 1; step_clk(); step = 0;
    tick(3 * P);
    check("t3_merged_step_edges", edges, 1);
    check("t3_merged_halt", run_state, S_HALT);

    // T4: breakpoint at 0x010, resume without re-trigger
    bp_addr = 12'h010; pc = 12'h00C; bp_en = 1; run = 1;
    wait_state(S_RUN, 2 * P, "t4_running");
    run = 0;
    wait_state(S_HALT, 12 * P, "t4_bp_halt");
    check("t4_bp_pc", pc, 12'h010);
    edges = 0;
    tick(2 * P);
    check("t4_bp_period_unclocked", edges, 0);
    check("t4_bp_pc_held", pc, 12'h010);
    run = 1;
    wait_state(S_RUN, 2 * P, "t4_resumed");
    tick(6 * P);
    check("t4_no_retrigger", run_state, S_RUN);
    check("t4_pc_advanced", (pc > 12'h011), 1);

    // T5: cycle_count wrap
    bp_en = 0;
    wait_ph(2);
    #1;
    force dut.cycle_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    wait_ph(5);
    #1;
    release dut.cycle_count;
    wait_ph(0);
    check("t5_count_wrap", cycle_count, 0);
    check("t5_wrap_edge", processor_clock, 1);

    // T6: reset in the middle of a step at ph=6
    run = 0; halt = 1;
    wait_state(S_HALT, 2 * P, "t6_halted");
    halt = 0;
    step = 1; step_clk(); step = 0;
    k = 0;
    while (!(m_state == S_STEP && m_ph == 6) && k < 4 * P) begin step_clk(); k++; end
    check("t6_in_step", run_state, S_STEP);
    #2 reset = 1'b0;
    #1;
    check("t6_state_hold", run_state, S_HOLD);
    check("t6_core_reset", core_reset, 1);
    check("t6_count_zero", cycle_count, 0);
    check("t6_proc_clk", processor_clock, 0);
    check("t6_regfile_clk", regfile_clock, 0);
    check("t6_imem_clk", imem_clock, 0);
    tick(3);
    reset = 1'b1;
    tick(2 * P);
    check("t6_hold_after_reset", run_state, S_HOLD);
    wait_state(S_RUN, 4 * P, "t6_run_after_hold");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        #2 reset = 1'b0;
        step_clk(); step_clk();
        reset = 1'b1;
      end else begin
        if ($urandom_range(0, 99) < 4) run = ~run;
        halt = ($urandom_range(0, 99) < 3);
        step = ($urandom_range(0, 99) < 5);
        if ($urandom_range(0, 199) == 0) bp_en = ~bp_en;
        if ($urandom_range(0, 99) == 0) bp_addr = pc + 12'($urandom_range(1, 6));
        step_clk();
      end
    end
    halt = 0; step = 0;
    tick(P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
